alu_reservation_station: RTL
============================

Name: alu_reservation_station

Overview:
- Tomasulo reservation-station bank feeding one ALU functional unit.
- Accepts dispatched ops whose source operands may still be pending by tag.
- Snoops the single-result CDB broadcast (tag + data) from the completion queue and captures operands on tag match.
- Issues the oldest fully-ready op to the ALU over a valid/ready handshake. The ALU result returns to the completion queue tagged with the station tag assigned here.

Parameters:
DEPTH, 4, number of station entries (2..8)
TAG_W, 4, width of producer/station tags
OP_W, 4, ALU opcode width
RS_ID_BASE, 1, station tag of entry 0; entry i has tag RS_ID_BASE+i
INVALID_TAG, 0, tag encoding meaning "no producer / operand present"

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
DISP_VALID  in  1  dispatch request
DISP_READY  out  1  at least one free entry
DISP_OP  in  OP_W  opcode
DISP_QJ  in  TAG_W  producer tag of operand A, INVALID_TAG if present
DISP_VJ  in  32  operand A value (used when DISP_QJ==INVALID_TAG)
DISP_QK  in  TAG_W  producer tag of operand B
DISP_VK  in  32  operand B value
DISP_TAG  out  TAG_W  station tag the current dispatch will receive
CDB_TAG  in  TAG_W  broadcast tag, INVALID_TAG = no broadcast
CDB_DATA  in  32  broadcast data
ISSUE_VALID  out  1  issue register holds an op
ISSUE_READY  in  1  ALU accepts op
ISSUE_OP  out  OP_W  issued opcode
ISSUE_A  out  32  operand A
ISSUE_B  out  32  operand B
ISSUE_TAG  out  TAG_W  station tag of issued op
OCCUPANCY  out  $clog2(DEPTH+1)  busy entries (excludes issue register)

Behaviour:
- Entry state: busy, op, qj, vj, qk, vk, plus dispatch-order age (age matrix or sequence number; only the ordering behaviour is specified).
- Reset: all entries not busy; ISSUE_VALID=0; ISSUE_OP/A/B/TAG=0; OCCUPANCY=0; DISP_READY=1.
- RST beats every other event, mid-operation included. All entries and the issue register are dropped; no handshake completes on that edge.
- Dispatch fires when DISP_VALID&&DISP_READY at the edge.
  - Target is the lowest-index free entry.
  - DISP_TAG = RS_ID_BASE + that index, combinational. Value is don't-care when DISP_READY=0.
  - DISP_READY depends on registered state only. An entry freed on the same edge cannot be reused on that edge.
- Dispatch-cycle CDB bypass: if DISP_QJ!=INVALID_TAG and DISP_QJ==CDB_TAG, store vj=CDB_DATA and qj=INVALID_TAG. Same rule for the K operand.
- Snoop: every busy entry with qj==CDB_TAG!=INVALID_TAG captures vj=CDB_DATA and clears qj. Same for qk. Both operands may capture from one broadcast.
- Ready means busy && qj==INVALID && qk==INVALID, evaluated on registered state. There is no CDB-to-issue forwarding in the same cycle.
- Issue register load:
  - Condition: (!ISSUE_VALID || ISSUE_READY) and some entry is ready.
  - Selects the oldest ready entry in dispatch order.
  - Copies op/vj/vk/tag into the issue register, sets ISSUE_VALID, and frees the entry on the same edge.
- Issue register drain: if ISSUE_READY && ISSUE_VALID and no entry is ready, ISSUE_VALID clears.
- Backpressure: while ISSUE_VALID && !ISSUE_READY, all ISSUE_* outputs hold stable.
- Latency:
  - Dispatch with both operands present at edge t gives ISSUE_VALID after edge t+1.
  - CDB capture at edge t gives issue after edge t+1.
  - Full throughput is one issue per cycle.
- Simultaneous dispatch and issue-load on one edge are both allowed (different entries). OCCUPANCY is unchanged in that case.
- OCCUPANCY: +1 on dispatch only, -1 on issue-load only. It never exceeds DEPTH and never wraps.
- The CDB tag never matches a free entry's fields; free-entry contents are don't-care.

Test Plan:
- Reset → after RST high for 1 edge: DISP_READY=1, ISSUE_VALID=0, OCCUPANCY=0, DISP_TAG=1.
- Dispatch OP=2, QJ=QK=0, VJ=5, VK=7 at edge 0 with ISSUE_READY=1 → after edge 1: ISSUE_VALID=1, A=5, B=7, OP=2, TAG=1; OCCUPANCY back to 0.
- Dispatch QJ=3, VK=9 → no issue for 5 idle cycles. CDB_TAG=3, DATA=0x10 at edge n → ISSUE_A=0x10, B=9 after edge n+1.
- Dispatch QJ=6 while CDB_TAG=6, DATA=0xAB the same cycle → captured via bypass; ISSUE_A=0xAB two edges later.
- Dispatch 4 ops with QJ=5,6,7,8 → DISP_READY=0, 5th dispatch held and DISP_TAG ignored. CDB tag 8 then tag 5 on consecutive cycles → issues tag 4 then tag 1. Then broadcast 7 and 6 in consecutive cycles with ISSUE_READY=0 during the second → tag 3 issues first (entry waiting on 7). The tag-2 op (waiting on 6) issues only after ISSUE_READY rises.
- ISSUE_READY=0 for 3 cycles with ISSUE_VALID=1 → A/B/OP/TAG constant. Concurrently dispatch a ready op → OCCUPANCY=1. Raise ISSUE_READY → the next op loads on that same edge.

Source files
------------

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Tomasulo reservation-station bank in front of a single ALU. Dispatched ops
//   wait for pending operands by producer tag. The bank snoops the CDB, and the
//   oldest fully-ready op is moved into a one-deep issue register.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   DISP_*                        dispatch handshake, operands and producer tags
//   DISP_TAG                      station tag the current dispatch will receive
//   CDB_TAG, CDB_DATA             result broadcast (INVALID_TAG = idle)
//   ISSUE_*                       valid/ready issue interface toward the ALU
//   OCCUPANCY                     busy entries, issue register excluded
module alu_reservation_station #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned OP_W        = 4,
   parameter int unsigned RS_ID_BASE  = 1,
   parameter int unsigned INVALID_TAG = 0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       DISP_VALID,
   output logic                       DISP_READY,
   input  logic [OP_W-1:0]            DISP_OP,
   input  logic [TAG_W-1:0]           DISP_QJ,
   input  logic [31:0]                DISP_VJ,
   input  logic [TAG_W-1:0]           DISP_QK,
   input  logic [31:0]                DISP_VK,
   output logic [TAG_W-1:0]           DISP_TAG,
   input  logic [TAG_W-1:0]           CDB_TAG,
   input  logic [31:0]                CDB_DATA,
   output logic                       ISSUE_VALID,
   input  logic                       ISSUE_READY,
   output logic [OP_W-1:0]            ISSUE_OP,
   output logic [31:0]                ISSUE_A,
   output logic [31:0]                ISSUE_B,
   output logic [TAG_W-1:0]           ISSUE_TAG,
   output logic [$clog2(DEPTH+1)-1:0] OCCUPANCY
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [TAG_W-1:0] InvTag = TAG_W'(INVALID_TAG);

   logic [DEPTH-1:0] busy_q;
   logic [OP_W-1:0]  op_q [DEPTH];
   logic [TAG_W-1:0] qj_q [DEPTH];
   logic [TAG_W-1:0] qk_q [DEPTH];
   logic [31:0]      vj_q [DEPTH];
   logic [31:0]      vk_q [DEPTH];
   // older_q[i][j] set: entry j was dispatched before entry i.
   logic [DEPTH-1:0] older_q [DEPTH];

   logic             issue_valid_q;
   logic [OP_W-1:0]  issue_op_q;
   logic [31:0]      issue_a_q;
   logic [31:0]      issue_b_q;
   logic [TAG_W-1:0] issue_tag_q;

   logic [DEPTH-1:0] ready;
   logic             any_ready;
   logic [IdxW-1:0]  sel_idx;
   logic             free_found;
   logic [IdxW-1:0]  free_idx;
   logic             issue_load;
   logic             disp_fire;
   logic             cdb_hit;
   logic [DEPTH-1:0] issue_mask;
   logic [CntW-1:0]  occ;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IdxW'(i);
         end
      end
   end

   // Oldest ready entry: the ready entry with no older ready entry.
   always_comb begin
      ready     = '0;
      any_ready = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ready[i] = busy_q[i] && (qj_q[i] == InvTag) && (qk_q[i] == InvTag);
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (ready[i] && ((older_q[i] & ready) == '0)) begin
            any_ready = 1'b1;
            sel_idx   = IdxW'(i);
         end
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         occ = occ + CntW'(busy_q[i]);
      end
   end

   assign cdb_hit    = (CDB_TAG != InvTag);
   assign issue_load = (!issue_valid_q || ISSUE_READY) && any_ready;
   assign disp_fire  = DISP_VALID && free_found;
   assign issue_mask = issue_load ? (DEPTH'(1) << sel_idx) : '0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q        <= '0;
         issue_valid_q <= 1'b0;
         issue_op_q    <= '0;
         issue_a_q     <= '0;
         issue_b_q     <= '0;
         issue_tag_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            op_q[i]    <= '0;
            qj_q[i]    <= InvTag;
            qk_q[i]    <= InvTag;
            vj_q[i]    <= '0;
            vk_q[i]    <= '0;
            older_q[i] <= '0;
         end
      end else begin
         // CDB snoop on waiting entries; a free entry never matches.
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (busy_q[i] && cdb_hit && (qj_q[i] == CDB_TAG)) begin
               qj_q[i] <= InvTag;
               vj_q[i] <= CDB_DATA;
            end
            if (busy_q[i] && cdb_hit && (qk_q[i] == CDB_TAG)) begin
               qk_q[i] <= InvTag;
               vk_q[i] <= CDB_DATA;
            end
         end

         if (issue_load) begin
            busy_q[sel_idx] <= 1'b0;
            issue_valid_q   <= 1'b1;
            issue_op_q      <= op_q[sel_idx];
            issue_a_q       <= vj_q[sel_idx];
            issue_b_q       <= vk_q[sel_idx];
            issue_tag_q     <= TAG_W'(RS_ID_BASE) + TAG_W'(sel_idx);
         end else if (ISSUE_READY && issue_valid_q) begin
            issue_valid_q <= 1'b0;
         end

         if (disp_fire) begin
            busy_q[free_idx] <= 1'b1;
            op_q[free_idx]   <= DISP_OP;
            // Dispatch-cycle bypass of a result broadcast on this same edge.
            if (DISP_QJ != InvTag && DISP_QJ == CDB_TAG) begin
               qj_q[free_idx] <= InvTag;
               vj_q[free_idx] <= CDB_DATA;
            end else begin
               qj_q[free_idx] <= DISP_QJ;
               vj_q[free_idx] <= DISP_VJ;
            end
            if (DISP_QK != InvTag && DISP_QK == CDB_TAG) begin
               qk_q[free_idx] <= InvTag;
               vk_q[free_idx] <= CDB_DATA;
            end else begin
               qk_q[free_idx] <= DISP_QK;
               vk_q[free_idx] <= DISP_VK;
            end
            // Clear stale column bits left by a previous occupant of this slot,
            // then record everything still in flight as older.
            for (int i = 0; i < int'(DEPTH); i++) begin
               older_q[i][free_idx] <= 1'b0;
            end
            older_q[free_idx] <= busy_q & ~issue_mask;
         end
      end
   end

   assign DISP_READY  = free_found;
   assign DISP_TAG    = TAG_W'(RS_ID_BASE) + TAG_W'(free_idx);
   assign ISSUE_VALID = issue_valid_q;
   assign ISSUE_OP    = issue_op_q;
   assign ISSUE_A     = issue_a_q;
   assign ISSUE_B     = issue_b_q;
   assign ISSUE_TAG   = issue_tag_q;
   assign OCCUPANCY   = occ;

endmodule
